// File: rtl/i2s_dac_tx.sv
// I2S / left-justified DAC serializer with a single-entry holding buffer.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified framing; standard I2S otherwise.
module i2s_dac_tx #(
   parameter int DATA_WIDTH = 16,
   parameter int SLOT_BITS  = 16,
   parameter int BCLK_DIV   = 6
) (
   input  logic                  sample_clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] left_sample,
   input  logic [DATA_WIDTH-1:0] right_sample,
   input  logic                  sample_valid,
   output logic                  sample_ready,
   output logic                  bclk,
   output logic                  daclrck,
   output logic                  dacdat,
   output logic                  frame_start,
   output logic                  underrun
);

   localparam int FRAME_BITS = 2 * SLOT_BITS;
   localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int K_W        = $clog2(FRAME_BITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [K_W-1:0]   K_LAST   = K_W'(FRAME_BITS - 1);
   localparam logic [K_W-1:0]   K_RIGHT  = K_W'(SLOT_BITS);

   logic [DIV_W-1:0]      div_q, div_d;
   logic                  bclk_q, bclk_d;
   logic [K_W-1:0]        k_q, k_d;
   logic                  lrck_q, lrck_d;
   logic                  dat_q, dat_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic                  full_q, full_d;
   logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
   logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
   logic                  fs_q, fs_d;
   logic                  ur_q, ur_d;

   logic                  div_tick;
   logic                  fall_evt;
   logic                  load;
   logic                  take;
   logic [FRAME_BITS-1:0] load_word;

   assign div_tick = (div_q == DIV_LAST);
   assign fall_evt = div_tick & bclk_q;
   assign load     = fall_evt & (k_q == '0);
   assign take     = sample_valid & ~full_q;

   // An empty holding buffer at frame load sends a silent frame.
   always_comb begin
      load_word = '0;
      if (full_q) begin
         load_word[FRAME_BITS-1 -: DATA_WIDTH] = hold_l_q;
         load_word[SLOT_BITS-1 -: DATA_WIDTH]  = hold_r_q;
      end
   end

   always_comb begin
      div_d    = div_tick ? '0 : div_q + DIV_W'(1);
      bclk_d   = bclk_q ^ div_tick;
      k_d      = k_q;
      lrck_d   = lrck_q;
      dat_d    = dat_q;
      shift_d  = shift_q;
      full_d   = full_q;
      hold_l_d = hold_l_q;
      hold_r_d = hold_r_q;
      fs_d     = load;
      ur_d     = load & ~full_q;

      if (fall_evt) begin
         k_d    = (k_q == K_LAST) ? '0 : k_q + K_W'(1);
         lrck_d = (k_q >= K_RIGHT);
         if (load) begin
`ifdef I2S_LEFT_JUSTIFIED_EN
            dat_d   = load_word[FRAME_BITS-1];
            shift_d = load_word << 1;
`else
            // After 2*SLOT_BITS-1 shifts the shifter MSB still holds the
            // previous frame's last bit, so it doubles as the I2S delay bit.
            dat_d   = shift_q[FRAME_BITS-1];
            shift_d = load_word;
`endif
         end else begin
            dat_d   = shift_q[FRAME_BITS-1];
            shift_d = shift_q << 1;
         end
      end

      if (take) begin
         full_d   = 1'b1;
         hold_l_d = left_sample;
         hold_r_d = right_sample;
      end else if (load) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge sample_clock or posedge reset) begin
      if (reset) begin
         div_q    <= '0;
         bclk_q   <= 1'b0;
         k_q      <= '0;
         lrck_q   <= 1'b0;
         dat_q    <= 1'b0;
         shift_q  <= '0;
         full_q   <= 1'b0;
         hold_l_q <= '0;
         hold_r_q <= '0;
         fs_q     <= 1'b0;
         ur_q     <= 1'b0;
      end else begin
         div_q    <= div_d;
         bclk_q   <= bclk_d;
         k_q      <= k_d;
         lrck_q   <= lrck_d;
         dat_q    <= dat_d;
         shift_q  <= shift_d;
         full_q   <= full_d;
         hold_l_q <= hold_l_d;
         hold_r_q <= hold_r_d;
         fs_q     <= fs_d;
         ur_q     <= ur_d;
      end
   end

   assign sample_ready = ~full_q;
   assign bclk         = bclk_q;
   assign daclrck      = lrck_q;
   assign dacdat       = dat_q;
   assign frame_start  = fs_q;
   assign underrun     = ur_q;

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- Serializer for the playback path: takes processed 16-bit left/right samples from the effect chain and drives the codec DAC serial interface (BCLK, DACLRCK, DACDAT).
- Generates bit and frame clocks from the single system clock. Codec runs as slave.
- Single-entry holding buffer with valid/ready handshake decouples the sample producer from frame timing.

Parameters:
- DATA_WIDTH, 16: sample width in bits.
- SLOT_BITS, 16: bit clocks per channel slot; must be >= DATA_WIDTH; unused LSB positions are sent as 0.
- BCLK_DIV, 6: sample_clock cycles per BCLK half-period; must be >= 2. Default gives 48 kHz frames from an 18.432 MHz clock.

Ports:
- sample_clock, input, 1: sole clock. All logic is on the rising edge.
- reset, input, 1: asynchronous, active-high.
- left_sample, input, DATA_WIDTH: left channel sample, two's complement.
- right_sample, input, DATA_WIDTH: right channel sample, two's complement.
- sample_valid, input, 1: the left/right pair is presented.
- sample_ready, output, 1: holding buffer is empty.
- bclk, output, 1: serial bit clock to the codec.
- daclrck, output, 1: frame clock to the codec; 0 = left slot, 1 = right slot.
- dacdat, output, 1: serial data to the codec. Changes on BCLK falling edges; the codec samples on rising edges.
- frame_start, output, 1: one-cycle pulse when a frame is loaded into the shifter.
- underrun, output, 1: one-cycle pulse when a frame is loaded while the holding buffer is empty.

Behaviour:
- Reset values (asynchronous):
  - bclk=0, daclrck=0, dacdat=0, frame_start=0, underrun=0.
  - All counters 0; shifter 0; delay bit 0.
  - Holding buffer empty, so sample_ready=1.
- Divider:
  - Counter runs 0..BCLK_DIV-1. At terminal count it wraps to 0 and toggles bclk.
  - A toggle 1->0 is a "fall event"; a toggle 0->1 is a "rise event".
  - First rise event occurs BCLK_DIV cycles after reset release; first fall event occurs 2*BCLK_DIV cycles after reset release.
- Bit position k:
  - Counts 0..2*SLOT_BITS-1 and advances by one on each fall event, wrapping to 0.
  - The first fall event after reset is k=0.
- Frame stream:
  - Stream is 2*SLOT_BITS bits: left sample MSB-first, zero-padded to SLOT_BITS, followed by right sample MSB-first, zero-padded.
- At the fall event with k=0 (frame load):
  - The shifter loads the holding pair, and holding becomes empty.
  - If holding was already empty, the shifter loads all zeros and underrun pulses.
  - frame_start pulses in the same cycle.
- At each fall event:
  - daclrck <= (k >= SLOT_BITS).
  - dacdat is updated per the framing mode (see Optional Feature).
- Handshake:
  - A transfer occurs when sample_valid && sample_ready at a rising clock edge. Holding captures both channels, and sample_ready=0 from the next cycle.
  - Inputs are ignored while sample_ready=0.
  - The producer must not assume the pair is consumed until sample_ready returns.
- Same-cycle transfer and frame load with holding empty:
  - The frame sends zeros and underrun pulses.
  - The transferred pair stays in holding for the next frame.
- Latency: a pair accepted before fall event k=0 appears in that frame; its MSB is on dacdat at k=0 (left-justified) or k=1 (I2S).
- Frame rate: sample_clock / (4*BCLK_DIV*SLOT_BITS).
- Reset asserted mid-frame: all outputs return to reset values immediately, any held pair is discarded, and framing restarts from k=0 after release.

Optional Feature:
- Macro: I2S_LEFT_JUSTIFIED_EN.
- Defined (left-justified mode):
  - dacdat at fall event k = stream[k].
  - MSB coincides with the daclrck edge.
- Undefined (standard I2S mode, default):
  - dacdat at fall event k = stream[k-1].
  - At k=0, dacdat is the final bit (index 2*SLOT_BITS-1) of the previous frame's stream, held in a delay register; this bit is 0 for the first frame after reset.
  - MSB appears one BCLK after the daclrck edge.
- Both modes:
  - daclrck timing and handshake are identical.
  - frame_start and underrun pulse on the same cycles.

Test Plan:
- Reset then idle, defaults: bclk period is 12 cycles; daclrck period is 384 cycles (32 BCLKs). dacdat stays 0, underrun pulses once per frame, and sample_ready=1 throughout.
- Push left=16'hA5C3, right=16'h0F01 before the first frame: I2S mode shows bits 1010_0101_1100_0011 on k=1..16, then 0000_1111_0000_0001 on k=17..31 plus bit 0 of the right sample at k=0 of the next frame. There is no underrun for this frame.
- Same pair with I2S_LEFT_JUSTIFIED_EN defined: left bits on k=0..15 and right bits on k=16..31. daclrck edges are at the same cycles as in I2S mode.
- Backpressure: hold sample_valid=1 with 16'h1111/16'h2222, then change the data to 16'h3333/16'h4444 while sample_ready=0. Only the first pair is transmitted until the next frame_start re-opens ready.
- Same-cycle sample_valid with frame load while holding is empty: that frame is zeros with an underrun pulse, and the pair is transmitted in the following frame.
- SLOT_BITS=24, DATA_WIDTH=16: 8 zero bits are padded after each channel, and the daclrck period is 96*BCLK_DIV cycles.
- Assert reset at k=20: all outputs go to 0 asynchronously and sample_ready=1. After release, the first fall event is again k=0, 2*BCLK_DIV cycles later.
